// File: rtl/edge_bus_sequencer.sv
// edge_bus_sequencer: bus master that walks every interior pixel of a frame,
// fetches its 3x3 neighbourhood, streams it to the edge core, and writes the
// core's result back to the output image region.
module edge_bus_sequencer #(
  parameter int          IMG_WIDTH  = 428,
  parameter int          IMG_HEIGHT = 428,
  parameter logic [31:0] RD_BASE    = 32'd0,
  parameter logic [31:0] WR_BASE    = 32'(IMG_WIDTH*IMG_HEIGHT+46)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  output logic        hsel,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [3:0]  pix_idx,
  input  logic        res_valid,
  input  logic [23:0] res_data,
  output logic        done
);

  localparam int CXW = $clog2(IMG_WIDTH);
  localparam int CYW = $clog2(IMG_HEIGHT);
  localparam logic [CXW-1:0] CX_LAST = CXW'(IMG_WIDTH-2);
  localparam logic [CYW-1:0] CY_LAST = CYW'(IMG_HEIGHT-2);
  localparam logic [31:0]    ROW     = 32'(IMG_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT_RES, S_WRITE, S_DONE} state_t;

  state_t         state;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [3:0]     idx;
  logic [1:0]     col;       // idx % 3, kept separately to avoid a divider
  logic [31:0]    win_base;  // read address of the window's top-left pixel
  logic [31:0]    wr_addr;   // write address of the current window centre

  logic last_col;
  logic last_win;
  assign last_col = (cx == CX_LAST);
  assign last_win = last_col && (cy == CY_LAST);

  // Only the RGB bits of a read word carry pixel data.
  logic unused_hrdata;
  assign unused_hrdata = &{1'b0, hrdata[31:24]};

  // Frame sequencer; all bus and core outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hsel      <= 1'b0;
      haddr     <= 32'd0;
      hwrite    <= 1'b0;
      hwdata    <= 32'd0;
      pix_valid <= 1'b0;
      pix_data  <= 24'd0;
      pix_idx   <= 4'd0;
      done      <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      idx       <= 4'd0;
      col       <= 2'd0;
      win_base  <= 32'd0;
      wr_addr   <= 32'd0;
    end else begin
      pix_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          hsel <= 1'b0;
          done <= 1'b0;
          if (!stop) begin
            state    <= S_READ;
            hsel     <= 1'b1;
            hwrite   <= 1'b0;
            haddr    <= RD_BASE;
            win_base <= RD_BASE;
            wr_addr  <= WR_BASE + ROW + 32'd1;
            cx       <= CXW'(1);
            cy       <= CYW'(1);
            idx      <= 4'd0;
            col      <= 2'd0;
          end
        end

        S_READ: begin
          // Nothing moves until the slave accepts the beat.
          if (hready) begin
            pix_valid <= 1'b1;
            pix_data  <= hrdata[23:0];
            pix_idx   <= idx;
            if (stop) begin
              state <= S_IDLE;
              hsel  <= 1'b0;
              cx    <= '0;
              cy    <= '0;
              idx   <= 4'd0;
              col   <= 2'd0;
            end else if (idx == 4'd8) begin
              state <= S_WAIT_RES;
              hsel  <= 1'b0;
              idx   <= 4'd0;
              col   <= 2'd0;
            end else begin
              idx <= idx + 4'd1;
              if (col == 2'd2) begin
                col   <= 2'd0;
                haddr <= haddr + ROW - 32'd2;
              end else begin
                col   <= col + 2'd1;
                haddr <= haddr + 32'd1;
              end
            end
          end
        end

        S_WAIT_RES: begin
          if (stop) begin
            state <= S_IDLE;
            cx    <= '0;
            cy    <= '0;
          end else if (res_valid) begin
            state  <= S_WRITE;
            hsel   <= 1'b1;
            hwrite <= 1'b1;
            haddr  <= wr_addr;
            hwdata <= {8'h00, res_data};
          end
        end

        S_WRITE: begin
          if (hready) begin
            hsel   <= 1'b0;
            hwrite <= 1'b0;
            if (stop) begin
              state <= S_IDLE;
              cx    <= '0;
              cy    <= '0;
            end else if (last_win) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // Next window: one pixel right, or first column of next row.
              state <= S_READ;
              hsel  <= 1'b1;
              idx   <= 4'd0;
              col   <= 2'd0;
              if (last_col) begin
                cx       <= CXW'(1);
                cy       <= cy + CYW'(1);
                win_base <= win_base + 32'd3;
                wr_addr  <= wr_addr + 32'd3;
                haddr    <= win_base + 32'd3;
              end else begin
                cx       <= cx + CXW'(1);
                win_base <= win_base + 32'd1;
                wr_addr  <= wr_addr + 32'd1;
                haddr    <= win_base + 32'd1;
              end
            end
          end
        end

        S_DONE: begin
          hsel <= 1'b0;
          done <= 1'b1;
          if (stop) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_bus_sequencer.sv
// Testbench for edge_bus_sequencer: 4x4 frame, randomized bus wait states,
// pixel memory and core latency, checked against a frame-level address model.
module tb_edge_bus_sequencer;

  localparam int          W    = 4;
  localparam int          H    = 4;
  localparam logic [31:0] RB   = 32'd0;
  localparam logic [31:0] WB   = 32'd100;
  localparam int          NWIN = (W-2)*(H-2);

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        stop = 1'b1;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [3:0]  pix_idx;
  logic        res_valid;
  logic [23:0] res_data;
  logic        done;

  edge_bus_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .RD_BASE(RB), .WR_BASE(WB)
  ) dut (
    .clk(tb_clk), .rst(rst), .stop(stop),
    .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_idx(pix_idx),
    .res_valid(res_valid), .res_data(res_data), .done(done)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       log_q[$];
  logic [23:0] res_q[$];
  logic [31:0] mem [0:15];

  int n_cmp = 0;
  int n_fail = 0;

  int ws_mode = 0;       // 0: no waits, 1: ws_fixed waits per beat, 2: random 0..3
  int ws_fixed = 0;
  int res_dmin = 0;
  int res_dmax = 0;
  bit core_en = 1'b1;
  bit stall_check = 1'b0;
  bit inject_stray = 1'b0;

  int          wait_cnt = 0;
  int          wait_target = -1;
  int          countdown = -1;
  bit          pix_pend = 1'b0;
  logic [23:0] pix_exp_data = 24'd0;
  logic [3:0]  pix_exp_idx = 4'd0;
  int          rd_in_win = 0;
  int          pix_cnt = 0;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_wdata = 32'd0;
  logic        prev_wr = 1'b0;

  // Bus slave, core model and continuous protocol checks, all at negedge.
  initial begin
    hready = 1'b0; hrdata = 32'd0; res_valid = 1'b0; res_data = 24'd0;
    forever begin
      @(negedge tb_clk);
      if (rst) begin
        hready = 1'b0;
        res_valid = 1'b0;
        hold_prev = 1'b0;
      end else begin
        if (pix_pend) begin
          n_cmp++;
          if (pix_valid !== 1'b1 || pix_data !== pix_exp_data || pix_idx !== pix_exp_idx) begin
            n_fail++;
            $display("FAIL pix_strobe: got valid=%b data=%h idx=%0d, want valid=1 data=%h idx=%0d",
                     pix_valid, pix_data, pix_idx, pix_exp_data, pix_exp_idx);
          end
          pix_pend = 1'b0;
        end else begin
          n_cmp++;
          if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pix_spurious: got valid=%b, want 0", pix_valid);
          end
        end
        if (pix_valid === 1'b1) pix_cnt++;

        if (hold_prev) begin
          n_cmp++;
          if (hsel !== 1'b1 || haddr !== prev_addr || hwrite !== prev_wr ||
              (prev_wr && hwdata !== prev_wdata)) begin
            n_fail++;
            $display("FAIL bus_hold: got hsel=%b addr=%0d wr=%b wdata=%h, want 1 %0d %b %h",
                     hsel, haddr, hwrite, hwdata, prev_addr, prev_wr, prev_wdata);
          end
        end

        res_valid = 1'b0;
        if (countdown == 0) begin
          res_data = 24'($urandom);
          res_valid = 1'b1;
          res_q.push_back(res_data);
          countdown = -1;
        end else if (countdown > 0) begin
          countdown--;
        end else if (inject_stray && hsel === 1'b1 && hwrite === 1'b0) begin
          res_valid = 1'b1;
          res_data = 24'hBADBAD;
          inject_stray = 1'b0;
        end
        if (stall_check && countdown > 0) begin
          n_cmp++;
          if (hsel !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hsel: got hsel=%b while core busy, want 0", hsel);
          end
        end
        if (core_en && pix_valid === 1'b1 && pix_idx == 4'd8)
          countdown = int'($urandom_range(res_dmax, res_dmin));

        if (hsel === 1'b1) begin
          if (wait_target < 0)
            wait_target = (ws_mode == 0) ? 0 : (ws_mode == 1) ? ws_fixed : int'($urandom_range(3, 0));
          hrdata = hwrite ? $urandom : {8'($urandom), mem[haddr[3:0]][23:0]};
          if (wait_cnt < wait_target) begin
            hready = 1'b0;
            wait_cnt++;
          end else begin
            hready = 1'b1;
            wait_cnt = 0;
            wait_target = -1;
            log_q.push_back('{haddr, hwrite, hwdata});
            if (hwrite === 1'b0) begin
              pix_pend = 1'b1;
              pix_exp_data = mem[haddr[3:0]][23:0];
              pix_exp_idx = 4'(rd_in_win);
              rd_in_win++;
            end else begin
              rd_in_win = 0;
            end
          end
        end else begin
          hready = 1'($urandom_range(1, 0));
          hrdata = $urandom;
          wait_cnt = 0;
          wait_target = -1;
        end
        hold_prev = (hsel === 1'b1 && hready === 1'b0);
        prev_addr = haddr;
        prev_wr = hwrite;
        prev_wdata = hwdata;
      end
    end
  end

  task automatic step();
    @(negedge tb_clk);
    #1;
  endtask

  task automatic clear_monitor();
    log_q.delete();
    res_q.delete();
    rd_in_win = 0;
    pix_cnt = 0;
    countdown = -1;
    pix_pend = 1'b0;
    hold_prev = 1'b0;
    wait_cnt = 0;
    wait_target = -1;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) mem[i] = {8'h00, 24'($urandom)};
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      step();
      if (done === 1'b1) break;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, want 1", done, budget);
    end
  endtask

  // Frame-level reference: raster walk of interior pixels, nine reads then a write each.
  task automatic check_frame(input string name);
    int i = 0;
    int w = 0;
    logic [31:0] ea;
    logic [31:0] ed;
    n_cmp++;
    if (log_q.size() != NWIN*10) begin
      n_fail++;
      $display("FAIL %s_len: got %0d transfers, want %0d", name, log_q.size(), NWIN*10);
    end
    for (int cy = 1; cy <= H-2; cy++) begin
      for (int cx = 1; cx <= W-2; cx++) begin
        for (int k = 0; k < 9; k++) begin
          ea = RB + 32'((cy + k/3 - 1)*W + (cx + k%3 - 1));
          if (i < log_q.size()) begin
            n_cmp++;
            if (log_q[i].addr !== ea || log_q[i].wr !== 1'b0) begin
              n_fail++;
              $display("FAIL %s_rd%0d: got addr=%0d wr=%b, want addr=%0d wr=0",
                       name, i, log_q[i].addr, log_q[i].wr, ea);
            end
          end
          i++;
        end
        ea = WB + 32'(cy*W + cx);
        ed = (w < res_q.size()) ? {8'h00, res_q[w]} : 32'hFFFF_FFFF;
        if (i < log_q.size()) begin
          n_cmp++;
          if (log_q[i].addr !== ea || log_q[i].wr !== 1'b1 || log_q[i].data !== ed) begin
            n_fail++;
            $display("FAIL %s_wr%0d: got addr=%0d wr=%b data=%h, want addr=%0d wr=1 data=%h",
                     name, i, log_q[i].addr, log_q[i].wr, log_q[i].data, ea, ed);
          end
        end
        i++;
        w++;
      end
    end
  endtask

  task automatic start_frame();
    stop = 1'b1;
    step();
    step();
    clear_monitor();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stop = 1'b1;
    step();
    n_cmp++;
    if ({hsel, haddr, hwrite, hwdata, pix_valid, pix_data, pix_idx, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got hsel=%b addr=%0d wr=%b wdata=%h pv=%b pd=%h pi=%0d done=%b, want all 0",
               hsel, haddr, hwrite, hwdata, pix_valid, pix_data, pix_idx, done);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (hsel !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: got hsel=%b done=%b, want 0 0", hsel, done);
      end
    end
    // Assert reset in the middle of a read burst.
    start_frame();
    for (int c = 0; c < 100 && log_q.size() < 3; c++) step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (hsel !== 1'b0 || haddr !== 32'd0 || done !== 1'b0 || hwrite !== 1'b0 ||
        pix_valid !== 1'b0 || pix_data !== 24'd0 || pix_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_async: got hsel=%b addr=%0d done=%b wr=%b pv=%b pd=%h pi=%0d, want all 0",
               hsel, haddr, done, hwrite, pix_valid, pix_data, pix_idx);
    end
    stop = 1'b1;
    step();
    clear_monitor();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (hsel !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release_idle: got hsel=%b, want 0", hsel);
      end
    end
  endtask

  task automatic test_frame();
    ws_mode = 0; res_dmin = 0; res_dmax = 0;
    start_frame();
    for (int c = 0; c < 1000 && log_q.size() < NWIN*10; c++) step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_early: got done=%b at final write, want 0", done);
    end
    step();
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done_rise: got done=%b cycle after final write, want 1", done);
    end
    n_cmp++;
    if (log_q.size() > 9 && log_q[9].addr !== 32'd105) begin
      n_fail++;
      $display("FAIL frame_first_write: got addr=%0d, want 105", log_q[9].addr);
    end
    check_frame("frame");
  endtask

  task automatic test_completion();
    int n0 = log_q.size();
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (done !== 1'b1 || hsel !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold: got done=%b hsel=%b, want 1 0", done, hsel);
      end
    end
    n_cmp++;
    if (log_q.size() != n0) begin
      n_fail++;
      $display("FAIL done_no_xfer: got %0d transfers, want %0d", log_q.size(), n0);
    end
    stop = 1'b1;
    step();
    step();
    n_cmp++;
    if (done !== 1'b0 || hsel !== 1'b0) begin
      n_fail++;
      $display("FAIL done_release: got done=%b hsel=%b, want 0 0", done, hsel);
    end
  endtask

  task automatic test_wait_states();
    ws_mode = 1; ws_fixed = 3; res_dmin = 0; res_dmax = 0;
    start_frame();
    wait_done(2000);
    check_frame("waits");
    n_cmp++;
    if (pix_cnt != NWIN*9) begin
      n_fail++;
      $display("FAIL waits_pix_count: got %0d pix_valid pulses, want %0d", pix_cnt, NWIN*9);
    end
  endtask

  task automatic test_core_stall();
    ws_mode = 0; res_dmin = 19; res_dmax = 19;
    stall_check = 1'b1;
    start_frame();
    inject_stray = 1'b1;
    wait_done(2000);
    stall_check = 1'b0;
    inject_stray = 1'b0;
    check_frame("stall");
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      randomize_mem();
      ws_mode = 2; res_dmin = 0; res_dmax = 6;
      start_frame();
      wait_done(2000);
      check_frame("random");
    end
  endtask

  task automatic test_abort();
    ws_mode = 1; ws_fixed = 5; res_dmin = 0; res_dmax = 0;
    start_frame();
    for (int c = 0; c < 200 && !(log_q.size() == 2 && hsel === 1'b1 && hready === 1'b0); c++) step();
    stop = 1'b1;
    for (int c = 0; c < 50 && log_q.size() < 3; c++) step();
    n_cmp++;
    if (log_q.size() != 3 || log_q[log_q.size()-1].addr !== RB + 32'd2) begin
      n_fail++;
      $display("FAIL abort_complete: got %0d transfers, want 3 ending at addr %0d", log_q.size(), RB + 32'd2);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (hsel !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle: got hsel=%b done=%b, want 0 0", hsel, done);
      end
    end
    n_cmp++;
    if (log_q.size() != 3) begin
      n_fail++;
      $display("FAIL abort_no_more: got %0d transfers, want 3", log_q.size());
    end
    ws_mode = 0;
    clear_monitor();
    stop = 1'b0;
    for (int c = 0; c < 20 && log_q.size() < 1; c++) step();
    n_cmp++;
    if (log_q.size() < 1 || log_q[0].addr !== RB || log_q[0].wr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart: got %0d transfers, first addr=%0d, want read at %0d",
               log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 32'hFFFF_FFFF, RB);
    end
    wait_done(2000);
    check_frame("restart");
  endtask

  initial begin
    randomize_mem();
    test_reset();
    test_frame();
    test_completion();
    test_wait_states();
    test_core_stall();
    test_abort();
    test_random();
    stop = 1'b1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
